// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types and constants for the 8-to-3 priority encoder
package prio_enc_pkg;

   localparam int WIDTH  = 8;
   localparam int CODE_W = 3;

   // rr_ptr reset value; the first round-robin search then starts at index 6
   localparam logic [CODE_W-1:0] RR_RESET_PTR = 3'd7;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc_if.sv
// rtl/prio_enc_if.sv - request/handshake bundle between encoder and its consumer
interface prio_enc_if;
   import prio_enc_pkg::*;

   logic              en;
   logic [WIDTH-1:0]  req;
   logic [WIDTH-1:0]  mask;
   logic [CODE_W-1:0] code;
   logic              valid;
   logic              ack;
   logic [WIDTH-1:0]  pending;
   logic              ovf;

   modport master (
      output en, req, mask, ack,
      input  code, valid, pending, ovf
   );

   modport slave (
      input  en, req, mask, ack,
      output code, valid, pending, ovf
   );

endinterface

// File: rtl/prio_sel.sv
// rtl/prio_sel.sv - find-first-set searching downward from a start index with wrap
module prio_sel
   import prio_enc_pkg::*;
(
   input  logic [WIDTH-1:0]  cand,
   input  logic [CODE_W-1:0] start,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   logic [CODE_W-1:0] pos;

   // Visit start, start-1, ... wrapping 0 -> 7; the first set bit wins
   always_comb begin
      idx = '0;
      any = 1'b0;
      pos = '0;
      for (int k = 0; k < WIDTH; k++) begin
         pos = start - CODE_W'(k);
         if (!any && cand[pos]) begin
            idx = pos;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_enc_8x3.sv
// rtl/prio_enc_8x3.sv - sticky 8-to-3 priority encoder with valid/ack; PRIO_ENC_RR_EN selects round-robin
module prio_enc_8x3
   import prio_enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   prio_enc_if.slave  bus
);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  pending_q, pending_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;

   logic [CODE_W-1:0] sel_start;
   logic [CODE_W-1:0] sel_idx;
   logic              sel_any;
   logic              xfer;
   logic [WIDTH-1:0]  clr_vec;

   assign xfer = valid_q && bus.ack;

`ifdef PRIO_ENC_RR_EN
   logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;

   assign sel_start = rr_ptr_q - 3'd1;

   // The last transferred index becomes the lowest priority for the next search
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = code_q;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= RR_RESET_PTR;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   assign sel_start = CODE_W'(WIDTH - 1);
`endif

   prio_sel u_sel (
      .cand  (pending_q & bus.mask),
      .start (sel_start),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   // Pending update: the transfer clears its bit, a same-cycle request sets it again
   always_comb begin
      clr_vec   = xfer ? (WIDTH'(1) << code_q) : '0;
      pending_d = (pending_q & ~clr_vec) | (bus.en ? bus.req : '0);
      ovf_d     = |(bus.req & pending_q & ~clr_vec);
   end

   // Handshake FSM: latch one candidate, hold it until acked, then idle for a cycle
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (bus.en && sel_any) begin
               state_d = PRESENT;
               code_d  = sel_idx;
               valid_d = 1'b1;
            end
         end
         PRESENT: begin
            if (bus.ack) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State, pending and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.code    = code_q;
   assign bus.valid   = valid_q;
   assign bus.pending = pending_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_prio_enc_8x3.sv
// tb/tb_prio_enc_8x3.sv - self-checking bench for prio_enc_8x3
module tb_prio_enc_8x3;

`ifdef PRIO_ENC_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic [7:0] mask;
      logic       ack;
      logic       exp_valid;
      logic [2:0] exp_code;
      logic [7:0] exp_pend;
      logic       exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   vec_t tbl[$];

   logic [7:0] m_pend;
   logic       m_valid;
   logic [2:0] m_code;
   logic       m_ovf;
   logic [2:0] m_rr;

   prio_enc_if bus ();

   prio_enc_8x3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [2:0] ref_pick(input logic [7:0] cand, input logic [2:0] rr);
      int s;
      int i;
      s = RR_MODE ? (int'(rr) + 7) % 8 : 7;
      for (int n = 0; n < 8; n++) begin
         i = (s - n + 8) % 8;
         if (cand[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   task automatic step(input bit chk);
      logic [7:0] clr;
      logic [7:0] n_pend;
      logic       n_ovf;
      logic       n_valid;
      logic [2:0] n_code;
      logic [2:0] n_rr;
      if (!rst_n) begin
         n_pend = 8'h00; n_ovf = 1'b0; n_valid = 1'b0; n_code = 3'd0; n_rr = 3'd7;
      end else begin
         clr     = (m_valid && bus.ack) ? 8'(1 << m_code) : 8'h00;
         n_ovf   = |(bus.req & m_pend & ~clr);
         n_pend  = (m_pend & ~clr) | (bus.en ? bus.req : 8'h00);
         n_valid = m_valid;
         n_code  = m_code;
         n_rr    = m_rr;
         if (!m_valid) begin
            if (bus.en && ((m_pend & bus.mask) != 8'h00)) begin
               n_valid = 1'b1;
               n_code  = ref_pick(m_pend & bus.mask, m_rr);
            end
         end else if (bus.ack) begin
            n_valid = 1'b0;
            n_rr    = m_code;
         end
      end
      @(posedge clk);
      m_pend = n_pend; m_ovf = n_ovf; m_valid = n_valid; m_code = n_code; m_rr = n_rr;
      #1;
      if (chk) begin
         check("model valid",   8'(bus.valid), 8'(m_valid));
         check("model code",    8'(bus.code),  8'(m_code));
         check("model pending", bus.pending,   m_pend);
         check("model ovf",     8'(bus.ovf),   8'(m_ovf));
      end
   endtask

   task automatic add(input logic en, input logic [7:0] req, input logic [7:0] mask, input logic ack,
                      input logic v, input logic [2:0] c, input logic [7:0] p, input logic o);
      vec_t r;
      r.en = en; r.req = req; r.mask = mask; r.ack = ack;
      r.exp_valid = v; r.exp_code = c; r.exp_pend = p; r.exp_ovf = o;
      tbl.push_back(r);
   endtask

   task automatic drive(input logic en, input logic [7:0] req, input logic [7:0] mask, input logic ack);
      bus.en = en; bus.req = req; bus.mask = mask; bus.ack = ack;
   endtask

   initial begin
`ifdef PRIO_ENC_RR_EN
      add(1, 8'hFF, 8'hFF, 0, 0, 3'd0, 8'hFF, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd6, 8'hFF, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd6, 8'hBF, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd5, 8'hBF, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd5, 8'h9F, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd4, 8'h9F, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd4, 8'h8F, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd3, 8'h8F, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd3, 8'h87, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd2, 8'h87, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd2, 8'h83, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd1, 8'h83, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd1, 8'h81, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd0, 8'h81, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd0, 8'h80, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd7, 8'h80, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd7, 8'h00, 0);
`else
      add(1, 8'h10, 8'hFF, 0, 0, 3'd0, 8'h10, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd4, 8'h10, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd4, 8'h00, 0);
      add(1, 8'h05, 8'hFF, 0, 0, 3'd4, 8'h05, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd2, 8'h05, 0);
      add(1, 8'h80, 8'hFF, 0, 1, 3'd2, 8'h85, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd2, 8'h81, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd7, 8'h81, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd7, 8'h01, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd0, 8'h01, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd0, 8'h00, 0);
      add(1, 8'h08, 8'hFF, 0, 0, 3'd0, 8'h08, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd3, 8'h08, 0);
      add(1, 8'h08, 8'hFF, 1, 0, 3'd3, 8'h08, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd3, 8'h08, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd3, 8'h00, 0);
      add(1, 8'h20, 8'hFF, 0, 0, 3'd3, 8'h20, 0);
      add(1, 8'h20, 8'hFF, 0, 1, 3'd5, 8'h20, 1);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd5, 8'h20, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 3'd5, 8'h00, 0);
      add(1, 8'h81, 8'h01, 0, 0, 3'd5, 8'h81, 0);
      add(1, 8'h00, 8'h01, 0, 1, 3'd0, 8'h81, 0);
      add(1, 8'h00, 8'h01, 1, 0, 3'd0, 8'h80, 0);
      add(0, 8'h00, 8'hFF, 0, 0, 3'd0, 8'h80, 0);
      add(0, 8'h01, 8'hFF, 0, 0, 3'd0, 8'h80, 0);
      add(1, 8'h00, 8'hFF, 0, 1, 3'd7, 8'h80, 0);
`endif

      // reset with all requests asserted
      rst_n = 1'b0;
      drive(1, 8'hFF, 8'hFF, 1);
      #1;
      step(0);
      step(0);
      check("reset valid",   8'(bus.valid), 8'h00);
      check("reset code",    8'(bus.code),  8'h00);
      check("reset pending", bus.pending,   8'h00);
      check("reset ovf",     8'(bus.ovf),   8'h00);
      rst_n = 1'b1;
      drive(1, 8'h00, 8'hFF, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].req, tbl[i].mask, tbl[i].ack);
         step(0);
         check($sformatf("row%0d valid", i),   8'(bus.valid), 8'(tbl[i].exp_valid));
         check($sformatf("row%0d code", i),    8'(bus.code),  8'(tbl[i].exp_code));
         check($sformatf("row%0d pending", i), bus.pending,   tbl[i].exp_pend);
         check($sformatf("row%0d ovf", i),     8'(bus.ovf),   8'(tbl[i].exp_ovf));
      end

      // reset while a code is presented
      rst_n = 1'b0;
      drive(1, 8'h00, 8'hFF, 0);
      step(0);
      rst_n = 1'b1;
      drive(1, 8'h02, 8'hFF, 0);
      step(0);
      drive(1, 8'h00, 8'hFF, 0);
      step(0);
      check("present before reset valid", 8'(bus.valid), 8'h01);
      check("present before reset code",  8'(bus.code),  8'h01);
      rst_n = 1'b0;
      step(0);
      check("reset in present valid",   8'(bus.valid), 8'h00);
      check("reset in present pending", bus.pending,   8'h00);
      check("reset in present code",    8'(bus.code),  8'h00);
      rst_n = 1'b1;

      // randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         drive(($urandom_range(0, 9) != 0),
               8'($urandom) & 8'($urandom) & 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
               1'($urandom));
         step(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
